// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared mips pipeline definitions for hazard control
// Contents: FSM state encodings, MEM_WAIT_MAX default, saturating counter helper.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERROR    = 2'b10,
    ST_ERROR_X  = 2'b11   // unused encoding, treated exactly like ST_ERROR
  } hz_state_e;

  localparam int unsigned MEM_WAIT_MAX_DEFAULT = 15;
  localparam logic [15:0] COUNT_SAT            = 16'hFFFF;

  // Event counters stick at all-ones rather than wrapping back to zero.
  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == COUNT_SAT) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational lw-followed-by-use hazard comparator
// Ports:
//   id_rs, id_rt     in  source register fields of the IF/ID instruction
//   id_uses_rt       in  IF/ID instruction reads rt
//   id_valid         in  IF/ID instruction is not a nop
//   ex_mem_read      in  ID/EX instruction is lw
//   ex_rt            in  lw destination register
//   load_use         out hazard: IF/ID reads the register the lw is still loading
module load_use_detect (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  output logic       load_use
);

  // $zero is never really written, so a lw targeting it cannot create a hazard.
  assign load_use = ex_mem_read && (ex_rt != 5'd0) && id_valid &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush/freeze controller with memory wait FSM
// Ports:
//   clock, reset                     in  system clock, synchronous active-high reset
//   id_rs, id_rt, id_uses_rt,
//   id_valid                         in  IF/ID instruction operand info
//   ex_mem_read, ex_rt               in  ID/EX lw info
//   mem_branch_taken, mem_access,
//   mem_ack                          in  EX/MEM branch and data memory handshake
//   pc_write, if_id_write            out PC and IF/ID load enables
//   if_id_flush, id_ex_bubble,
//   ex_mem_flush                     out stage flush/bubble controls
//   pipe_freeze                      out hold ID/EX, EX/MEM, MEM/WB
//   state                            out current FSM state
//   mem_timeout                      out sticky memory timeout flag
//   stall_count, flush_count         out saturating event counters
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = MEM_WAIT_MAX_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_valid,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        mem_branch_taken,
  input  logic        mem_access,
  input  logic        mem_ack,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        ex_mem_flush,
  output logic        pipe_freeze,
  output logic [1:0]  state,
  output logic        mem_timeout,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

  hz_state_e  cur_state, nxt_state;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       load_use;
  logic       advance;
  logic       set_timeout;
  logic       branch_flush;

  load_use_detect u_load_use_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .id_valid    (id_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .load_use    (load_use)
  );

  assign state = cur_state;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_flush = 1'b0;
    pipe_freeze  = 1'b0;
    nxt_state    = cur_state;
    wait_cnt_nxt = wait_cnt;
    advance      = 1'b0;
    set_timeout  = 1'b0;
    branch_flush = 1'b0;

    // During reset the outputs stay at their free-running values.
    if (!reset) begin
      case (cur_state)
        ST_RUN: begin
          if (mem_access && !mem_ack) begin
            pipe_freeze  = 1'b1;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            nxt_state    = ST_MEM_WAIT;
            wait_cnt_nxt = 8'd1;
          end else begin
            advance = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ack) begin
            // Access completes: unfreeze this cycle and let hazards act as in RUN.
            nxt_state = ST_RUN;
            advance   = 1'b1;
          end else begin
            pipe_freeze  = 1'b1;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            wait_cnt_nxt = wait_cnt + 8'd1;
            if (wait_cnt == WAIT_LIMIT) begin
              nxt_state   = ST_ERROR;
              set_timeout = 1'b1;
            end
          end
        end
        default: begin
          pipe_freeze = 1'b1;
          pc_write    = 1'b0;
          if_id_write = 1'b0;
        end
      endcase

      // A taken branch squashes the younger instructions, so any load-use
      // hazard among them is moot and the PC must load the target.
      if (advance) begin
        if (mem_branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          ex_mem_flush = 1'b1;
          branch_flush = 1'b1;
        end else if (load_use) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_state   <= ST_RUN;
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
      stall_count <= 16'd0;
      flush_count <= 16'd0;
    end else begin
      cur_state <= nxt_state;
      wait_cnt  <= wait_cnt_nxt;
      if (set_timeout) begin
        mem_timeout <= 1'b1;
      end
      if (!pc_write) begin
        stall_count <= sat_inc(stall_count);
      end
      if (branch_flush) begin
        flush_count <= sat_inc(flush_count);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard testbench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  // Control vector order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_freeze}
  localparam logic [5:0] C_RUN = 6'b110000;
  localparam logic [5:0] C_LU  = 6'b000100;
  localparam logic [5:0] C_BR  = 6'b111110;
  localparam logic [5:0] C_FRZ = 6'b000001;
  localparam logic [1:0] S_RUN = 2'b00;
  localparam logic [1:0] S_MW  = 2'b01;
  localparam logic [1:0] S_ERR = 2'b10;

  logic        clock;
  logic        reset;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        id_valid;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        mem_branch_taken;
  logic        mem_access;
  logic        mem_ack;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        ex_mem_flush;
  logic        pipe_freeze;
  logic [1:0]  state;
  logic        mem_timeout;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  pipe_hazard_ctrl #(.MEM_WAIT_MAX(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_uses_rt       (id_uses_rt),
    .id_valid         (id_valid),
    .ex_mem_read      (ex_mem_read),
    .ex_rt            (ex_rt),
    .mem_branch_taken (mem_branch_taken),
    .mem_access       (mem_access),
    .mem_ack          (mem_ack),
    .pc_write         (pc_write),
    .if_id_write      (if_id_write),
    .if_id_flush      (if_id_flush),
    .id_ex_bubble     (id_ex_bubble),
    .ex_mem_flush     (ex_mem_flush),
    .pipe_freeze      (pipe_freeze),
    .state            (state),
    .mem_timeout      (mem_timeout),
    .stall_count      (stall_count),
    .flush_count      (flush_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [5:0]  ctl;
    logic [1:0]  st;
    logic        to;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_sc   = 0;
  int   exp_fc   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock cycle: drive inputs after the edge, queue the expectation,
  // then compare at the falling edge once the outputs have settled.
  task automatic step(input string tag, input logic rst,
                      input logic [4:0] rs, input logic [4:0] rt, input logic urt, input logic vld,
                      input logic lw, input logic [4:0] ert,
                      input logic br, input logic acc, input logic ack,
                      input logic [5:0] ctl, input logic [1:0] st, input logic to);
    exp_t e;
    exp_t g;
    @(posedge clock);
    #1;
    reset            = rst;
    id_rs            = rs;
    id_rt            = rt;
    id_uses_rt       = urt;
    id_valid         = vld;
    ex_mem_read      = lw;
    ex_rt            = ert;
    mem_branch_taken = br;
    mem_access       = acc;
    mem_ack          = ack;
    e.tag = tag;
    e.ctl = ctl;
    e.st  = st;
    e.to  = to;
    e.sc  = 16'(exp_sc);
    e.fc  = 16'(exp_fc);
    sb.push_back(e);
    @(negedge clock);
    g = sb.pop_front();
    check_eq({g.tag, ".ctl"}, {26'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_freeze}, {26'd0, g.ctl});
    check_eq({g.tag, ".state"}, {30'd0, state}, {30'd0, g.st});
    check_eq({g.tag, ".timeout"}, {31'd0, mem_timeout}, {31'd0, g.to});
    check_eq({g.tag, ".stall_count"}, {16'd0, stall_count}, {16'd0, g.sc});
    check_eq({g.tag, ".flush_count"}, {16'd0, flush_count}, {16'd0, g.fc});
    if (rst) begin
      exp_sc = 0;
      exp_fc = 0;
    end else begin
      if (!ctl[5]) exp_sc++;
      if (ctl[3])  exp_fc++;
    end
  endtask

  initial begin
    reset = 1'b1;
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_valid = 1'b0;
    ex_mem_read = 1'b0; ex_rt = 5'd0;
    mem_branch_taken = 1'b0; mem_access = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clock);

    //   tag         rst rs     rt     urt vld lw ert    br acc ack ctl    state  to
    step("rst",      1, 5'd0,  5'd0,  0,  0,  0, 5'd0,  1, 1,  0,  C_RUN, S_RUN, 0);
    step("idle",     0, 5'd0,  5'd0,  0,  0,  0, 5'd0,  0, 0,  0,  C_RUN, S_RUN, 0);
    step("lu_rs",    0, 5'd2,  5'd7,  1,  1,  1, 5'd2,  0, 0,  0,  C_LU,  S_RUN, 0);
    step("after_lu", 0, 5'd2,  5'd7,  1,  1,  0, 5'd0,  0, 0,  0,  C_RUN, S_RUN, 0);
    step("nf_zero",  0, 5'd0,  5'd0,  1,  1,  1, 5'd0,  0, 0,  0,  C_RUN, S_RUN, 0);
    step("nf_nop",   0, 5'd2,  5'd0,  0,  0,  1, 5'd2,  0, 0,  0,  C_RUN, S_RUN, 0);
    step("lu_rt",    0, 5'd1,  5'd5,  1,  1,  1, 5'd5,  0, 0,  0,  C_LU,  S_RUN, 0);
    step("nf_rt",    0, 5'd1,  5'd5,  0,  1,  1, 5'd5,  0, 0,  0,  C_RUN, S_RUN, 0);
    step("br",       0, 5'd0,  5'd0,  0,  1,  0, 5'd0,  1, 0,  0,  C_BR,  S_RUN, 0);
    step("br_lu",    0, 5'd2,  5'd0,  0,  1,  1, 5'd2,  1, 0,  0,  C_BR,  S_RUN, 0);
    step("zero_wait",0, 5'd0,  5'd0,  0,  1,  0, 5'd0,  0, 1,  1,  C_RUN, S_RUN, 0);
    step("mw0",      0, 5'd0,  5'd0,  0,  1,  0, 5'd0,  0, 1,  0,  C_FRZ, S_RUN, 0);
    step("mw1",      0, 5'd0,  5'd0,  0,  1,  0, 5'd0,  0, 1,  0,  C_FRZ, S_MW,  0);
    step("mw2",      0, 5'd0,  5'd0,  0,  1,  0, 5'd0,  0, 1,  0,  C_FRZ, S_MW,  0);
    step("mw_ack",   0, 5'd0,  5'd0,  0,  1,  0, 5'd0,  0, 1,  1,  C_RUN, S_MW,  0);
    step("post_mw",  0, 5'd0,  5'd0,  0,  1,  0, 5'd0,  0, 0,  0,  C_RUN, S_RUN, 0);
    step("mwb0",     0, 5'd0,  5'd0,  0,  1,  0, 5'd0,  1, 1,  0,  C_FRZ, S_RUN, 0);
    step("mwb_ack",  0, 5'd0,  5'd0,  0,  1,  0, 5'd0,  1, 1,  1,  C_BR,  S_MW,  0);
    step("post_mwb", 0, 5'd0,  5'd0,  0,  1,  0, 5'd0,  0, 0,  0,  C_RUN, S_RUN, 0);
    step("to0",      0, 5'd0,  5'd0,  0,  1,  0, 5'd0,  0, 1,  0,  C_FRZ, S_RUN, 0);
    step("to1",      0, 5'd0,  5'd0,  0,  1,  0, 5'd0,  0, 1,  0,  C_FRZ, S_MW,  0);
    step("to2",      0, 5'd0,  5'd0,  0,  1,  0, 5'd0,  0, 1,  0,  C_FRZ, S_MW,  0);
    step("to3",      0, 5'd0,  5'd0,  0,  1,  0, 5'd0,  0, 1,  0,  C_FRZ, S_MW,  0);
    step("to4",      0, 5'd0,  5'd0,  0,  1,  0, 5'd0,  0, 1,  0,  C_FRZ, S_MW,  0);
    step("err0",     0, 5'd0,  5'd0,  0,  1,  0, 5'd0,  0, 0,  0,  C_FRZ, S_ERR, 1);
    step("err1",     0, 5'd0,  5'd0,  0,  1,  0, 5'd0,  1, 1,  1,  C_FRZ, S_ERR, 1);
    step("rst_err",  1, 5'd0,  5'd0,  0,  1,  0, 5'd0,  0, 1,  0,  C_RUN, S_ERR, 1);
    step("after_rst",0, 5'd0,  5'd0,  0,  1,  0, 5'd0,  0, 0,  0,  C_RUN, S_RUN, 0);
    step("m0",       0, 5'd0,  5'd0,  0,  1,  0, 5'd0,  0, 1,  0,  C_FRZ, S_RUN, 0);
    step("rst_mw",   1, 5'd0,  5'd0,  0,  1,  0, 5'd0,  0, 1,  0,  C_RUN, S_MW,  0);
    step("final",    0, 5'd0,  5'd0,  0,  1,  0, 5'd0,  0, 0,  0,  C_RUN, S_RUN, 0);

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: MEM_WAIT_MAX, default 15, maximum number of MEM_WAIT cycles before timeout (range 1..255).
REQ-002 clock  in  1  single system clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 id_rs  in  5  rs field of the instruction in IF/ID.
REQ-005 id_rt  in  5  rt field of the instruction in IF/ID.
REQ-006 id_uses_rt  in  1  the IF/ID instruction reads rt (R-type, beq, sw).
REQ-007 id_valid  in  1  the IF/ID instruction is not a nop (word not equal to 32'b0).
REQ-008 ex_mem_read  in  1  the ID/EX instruction is lw.
REQ-009 ex_rt  in  5  destination rt of the ID/EX instruction.
REQ-010 mem_branch_taken  in  1  branch AND zero in the EX/MEM stage (PCSrc).
REQ-011 mem_access  in  1  memRead OR memWrite in the EX/MEM stage.
REQ-012 mem_ack  in  1  data memory has completed the current access this cycle.
REQ-013 pc_write  out  1  PC register load enable.
REQ-014 if_id_write  out  1  IF/ID load enable.
REQ-015 if_id_flush  out  1  load nop (32'b0) into IF/ID.
REQ-016 id_ex_bubble  out  1  load zero control (WB/MEM/EXE = 0) into ID/EX.
REQ-017 ex_mem_flush  out  1  load zero control into EX/MEM.
REQ-018 pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB unchanged.
REQ-019 state  out  2  current FSM state encoding.
REQ-020 mem_timeout  out  1  sticky memory-timeout error flag.
REQ-021 stall_count  out  16  count of cycles with pc_write=0.
REQ-022 flush_count  out  16  count of branch flush events.

Function
REQ-023 The FSM SHALL have three states: RUN=2'b00, MEM_WAIT=2'b01, ERROR=2'b10; 2'b11 SHALL behave as ERROR.
REQ-024 load_use SHALL be ex_mem_read AND ex_rt!=0 AND id_valid AND (ex_rt==id_rs OR (id_uses_rt AND ex_rt==id_rt)).
REQ-025 Outputs are combinational from the state and inputs. Priority within RUN: memory wait, then branch flush, then load-use.
REQ-026 RUN, mem_access=1, mem_ack=0: pipe_freeze=1, pc_write=0, if_id_write=0, all flushes 0; next state MEM_WAIT, wait counter cleared to 1.
REQ-027 RUN, mem_access=1, mem_ack=1: zero-wait access; no stall is generated by the memory.
REQ-028 RUN, mem_branch_taken=1 (no memory wait): pc_write=1 (loads the target), if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1; flush_count increments.
REQ-029 RUN, load_use=1, no branch, no memory wait: pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly that cycle. The hazard self-clears once the lw reaches MEM.
REQ-030 RUN, no event: pc_write=1, if_id_write=1, all other control outputs 0.
REQ-031 MEM_WAIT: pipe_freeze=1, pc_write=0, if_id_write=0. The wait counter increments each cycle.
REQ-032 MEM_WAIT, mem_ack=1: freeze deasserts in the same cycle, the pipeline advances, next state RUN. A branch held in MEM in that cycle is flushed per REQ-028.
REQ-033 MEM_WAIT: if the wait counter equals MEM_WAIT_MAX and mem_ack=0, next state is ERROR and mem_timeout is set.
REQ-034 ERROR: pipe_freeze=1, pc_write=0, if_id_write=0. ERROR is left only by reset.
REQ-035 stall_count and flush_count SHALL saturate at 16'hFFFF and never wrap.

Reset
REQ-036 On reset: state=RUN, wait counter=0, mem_timeout=0, stall_count=0, flush_count=0.
REQ-037 Reset SHALL override any state, including MEM_WAIT and ERROR mid-operation. Outputs in the reset cycle SHALL follow RUN/no-event values per REQ-030.

Structure
REQ-038 State encodings and the MEM_WAIT_MAX default SHALL live in the shared mips pipeline definitions package.
REQ-039 The load-use comparator SHALL be a separate combinational sub-module, load_use_detect.

Verification
REQ-040 Load-use: lw $2 in ID/EX (ex_rt=2), add using rs=2 in IF/ID -> one cycle with pc_write=0, id_ex_bubble=1; stall_count=1.
REQ-041 No false hazard: ex_rt=0 with id_rs=0, or id_valid=0 -> no stall.
REQ-042 Branch flush: mem_branch_taken=1 -> if_id_flush=id_ex_bubble=ex_mem_flush=1 for one cycle; flush_count=1.
REQ-043 Wait states: mem_access=1 with mem_ack arriving after 3 cycles -> state=MEM_WAIT, pipe_freeze=1 for 3 cycles then RUN; stall_count=3.
REQ-044 Timeout: MEM_WAIT_MAX=4, no ack -> state=ERROR and mem_timeout=1 after 5 cycles and persisting; reset -> all registers 0 and state=RUN.
REQ-045 Simultaneous: load_use and mem_branch_taken in the same cycle -> flush only, pc_write=1.
